ecat_datagram_parser: RTL and testbench
=======================================

Name: ecat_datagram_parser

Overview:
Receive-side EtherCAT datagram decoder. It walks the byte stream of an EtherCAT frame's datagram area and extracts each datagram header: command, index, 32-bit logical address, length and the more-follows flag. It drives the sub_* / subdv interface consumed by the FMMU process block, qualifies every data byte with its offset, and captures the incoming working counter. It is the initiator of the per-datagram transaction that the FMMU responds to.

Parameters:
MAX_LEN, 11'd1486, largest legal datagram data length; larger length fields are flagged as errors.

Ports:
rxc  in  1  byte clock; single clock domain.
RST  in  1  synchronous, active-high reset.
rx_data  in  8  received byte, valid when rx_dv=1.
rx_dv  in  1  byte valid; low inside a datagram means the frame was truncated.
frame_start  in  1  1-cycle pulse coincident with the first byte of the datagram area (header byte 0).
sub_command  out  8  datagram command byte (LRD=0x0A, LWR=0x0B, LRW=0x0C).
sub_index  out  8  datagram index byte.
sub_address  out  32  logical address, assembled little-endian.
sub_len  out  16  data length: {5'b0, len[10:0]}.
sub_more  out  1  M bit (bit 15 of the length word).
subdv  out  1  data-byte qualifier, aligned with rx_data.
data_idx  out  11  offset of the current data byte (0..sub_len-1), valid while subdv=1.
wkc_in  out  16  received working counter, little-endian.
dgram_done  out  1  1-cycle pulse after the last WKC byte.
frame_done  out  1  1-cycle pulse after the WKC of the datagram with M=0.
err  out  1  1-cycle pulse on truncation, restart, or oversize length.

Behaviour:
- Reset (RST=1 at a rxc edge): state IDLE. All registered outputs are 0. subdv=0.
- States: IDLE, HDR, DATA, WKC.
- Header layout, 10 bytes: cmd, idx, addr[7:0], addr[15:8], addr[23:16], addr[31:24], lenlo, lenhi, irqlo, irqhi. len = {lenhi[2:0], lenlo}; M = lenhi[7]; the IRQ bytes are consumed and discarded.
- IDLE: when frame_start=1 and rx_dv=1, the byte is captured as cmd, hdr_cnt is set to 1, and the state moves to HDR. All other bytes are ignored.
- HDR: each rx_dv byte is stored into a shadow register by hdr_cnt, then hdr_cnt increments. Shadow values are copied to the sub_* outputs on the cycle of byte 9, so they are visible from the next cycle. They hold stable through DATA and WKC, until the next header completes.
- End of header with len=0: go to WKC.
- End of header with len>MAX_LEN: pulse err and go to IDLE. Outputs are still published.
- End of header otherwise: go to DATA with data_cnt=0.
- DATA: subdv = (state==DATA) & rx_dv (combinational, same cycle as the byte). data_idx = data_cnt. data_cnt increments per byte. On the byte with data_cnt==len-1, go to WKC.
- WKC: byte 0 goes to wkc_in[7:0], byte 1 goes to wkc_in[15:8]. dgram_done pulses the cycle after byte 1.
  - If sub_more=1: go to HDR with hdr_cnt=0.
  - Else: pulse frame_done together with dgram_done and go to IDLE.
- Latency: sub_* fields are valid 1 cycle after header byte 9. subdv has zero latency.
- rx_dv=0 in HDR, DATA or WKC: pulse err next cycle, go to IDLE, force subdv low. Partially captured shadow fields are not published.
- frame_start=1 outside IDLE: pulse err and restart, treating the byte as cmd (hdr_cnt=1, state HDR).
- Bytes arriving after frame_done are ignored until the next frame_start.
- Counters are sized to MAX_LEN and never wrap within a legal datagram.
- sub_address arithmetic is pure concatenation; there is no sign extension.

Decomposition:
- Shared package ecat_pkg:
  - Command constants: CMD_LRD=8'h0A, CMD_LWR=8'h0B, CMD_LRW=8'h0C.
  - Header byte-offset constants (HDR_LEN=10, OFF_ADDR=2, OFF_LEN=6).
  - State encoding.
  - LEN_W=11.
- No sub-module; the FSM and capture logic stay in one module.

Test Plan:
1. Basic LRD. frame_start with bytes 0A 01 00 00 01 00 04 00 00 00, data 11 22 33 44, WKC 00 00.
   Required: sub_command=0x0A, sub_address=0x00010000, sub_len=4, sub_more=0. subdv high for 4 cycles with data_idx 0,1,2,3. wkc_in=0x0000. dgram_done and frame_done each pulse once.
2. Chained datagrams. An LWR (0x0B, addr 0x00001000, len 2, lenhi=0x80) followed by an LRW (0x0C, addr 0x00002000, len 1, M=0).
   Required: the first dgram_done has no frame_done. The second header's fields appear only after its byte 9. frame_done pulses once, at the end.
3. Zero length. Header with len=0, then WKC 05 00.
   Required: subdv never asserts, wkc_in=0x0005, dgram_done pulses.
4. Truncation. rx_dv drops after data byte 2 of a len=8 datagram.
   Required: err pulses once, subdv goes low, state returns to IDLE, and no dgram_done occurs.
5. Oversize and restart. A len field of 0x7FF gives an err pulse. A frame_start at header byte 4 gives an err pulse, and the following bytes parse as a new header.
6. Reset mid-DATA. RST=1 for 1 cycle.
   Required: all outputs read 0 on the next cycle, and the bytes that follow are ignored until frame_start.

Source files
------------

// File: rtl/ecat_pkg.sv
// Shared constants and state encoding for the EtherCAT datagram parser.
// Header offsets count bytes from the command byte.
package ecat_pkg;

    localparam logic [7:0] CMD_LRD = 8'h0A;
    localparam logic [7:0] CMD_LWR = 8'h0B;
    localparam logic [7:0] CMD_LRW = 8'h0C;

    localparam int LEN_W = 11;

    localparam logic [3:0] HDR_LEN  = 4'd10;
    localparam logic [3:0] OFF_ADDR = 4'd2;
    localparam logic [3:0] OFF_LEN  = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WKC
    } state_t;

endpackage

// File: rtl/ecat_datagram_parser.sv
// Receive-side EtherCAT datagram decoder: extracts header fields, qualifies
// data bytes with their offset and captures the working counter.
module ecat_datagram_parser
    import ecat_pkg::*;
#(
    parameter logic [LEN_W-1:0] MAX_LEN = 11'd1486
) (
    input  logic             rxc,
    input  logic             RST,
    input  logic [7:0]       rx_data,
    input  logic             rx_dv,
    input  logic             frame_start,
    output logic [7:0]       sub_command,
    output logic [7:0]       sub_index,
    output logic [31:0]      sub_address,
    output logic [15:0]      sub_len,
    output logic             sub_more,
    output logic             subdv,
    output logic [LEN_W-1:0] data_idx,
    output logic [15:0]      wkc_in,
    output logic             dgram_done,
    output logic             frame_done,
    output logic             err
);

    state_t state, state_d;

    logic [3:0]       hdr_cnt;
    logic [LEN_W-1:0] data_cnt;
    logic             wkc_cnt;

    // Shadow header; only published once the whole header has arrived
    logic [7:0]  sh_cmd;
    logic [7:0]  sh_idx;
    logic [31:0] sh_addr;
    logic [7:0]  sh_len_lo;
    logic [2:0]  sh_len_hi;
    logic        sh_more;

    logic [LEN_W-1:0] hdr_len;
    logic [LEN_W-1:0] cur_len;

    logic err_d, dg_d, fd_d;
    logic take_cmd, hdr_store, publish, data_step, wkc_store;

    assign hdr_len  = {sh_len_hi, sh_len_lo};
    assign cur_len  = sub_len[LEN_W-1:0];
    assign data_idx = data_cnt;
    assign subdv    = (state == ST_DATA) && rx_dv;

    always_comb begin
        state_d   = state;
        err_d     = 1'b0;
        dg_d      = 1'b0;
        fd_d      = 1'b0;
        take_cmd  = 1'b0;
        hdr_store = 1'b0;
        publish   = 1'b0;
        data_step = 1'b0;
        wkc_store = 1'b0;
        if (state == ST_IDLE) begin
            if (frame_start && rx_dv) begin
                take_cmd = 1'b1;
                state_d  = ST_HDR;
            end
        end else if (!rx_dv) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else if (frame_start) begin
            err_d    = 1'b1;
            take_cmd = 1'b1;
            state_d  = ST_HDR;
        end else begin
            unique case (state)
                ST_HDR: begin
                    hdr_store = 1'b1;
                    if (hdr_cnt == HDR_LEN - 4'd1) begin
                        publish = 1'b1;
                        if (hdr_len == '0) begin
                            state_d = ST_WKC;
                        end else if (hdr_len > MAX_LEN) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    data_step = 1'b1;
                    if (data_cnt == cur_len - 1'b1) state_d = ST_WKC;
                end
                ST_WKC: begin
                    wkc_store = 1'b1;
                    if (wkc_cnt) begin
                        dg_d = 1'b1;
                        if (sub_more) begin
                            state_d = ST_HDR;
                        end else begin
                            fd_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rxc) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge rxc) begin
        if (RST) begin
            hdr_cnt     <= '0;
            data_cnt    <= '0;
            wkc_cnt     <= 1'b0;
            sh_cmd      <= '0;
            sh_idx      <= '0;
            sh_addr     <= '0;
            sh_len_lo   <= '0;
            sh_len_hi   <= '0;
            sh_more     <= 1'b0;
            sub_command <= '0;
            sub_index   <= '0;
            sub_address <= '0;
            sub_len     <= '0;
            sub_more    <= 1'b0;
            wkc_in      <= '0;
            dgram_done  <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            err        <= err_d;
            dgram_done <= dg_d;
            frame_done <= fd_d;

            if (take_cmd) begin
                sh_cmd  <= rx_data;
                hdr_cnt <= 4'd1;
            end else if (hdr_store) begin
                case (hdr_cnt)
                    4'd0:            sh_cmd        <= rx_data;
                    4'd1:            sh_idx        <= rx_data;
                    OFF_ADDR:        sh_addr[7:0]  <= rx_data;
                    OFF_ADDR + 4'd1: sh_addr[15:8] <= rx_data;
                    OFF_ADDR + 4'd2: sh_addr[23:16] <= rx_data;
                    OFF_ADDR + 4'd3: sh_addr[31:24] <= rx_data;
                    OFF_LEN:         sh_len_lo     <= rx_data;
                    OFF_LEN + 4'd1: begin
                        sh_len_hi <= rx_data[2:0];
                        sh_more   <= rx_data[7];
                    end
                    default: ;
                endcase
                hdr_cnt <= hdr_cnt + 4'd1;
            end else if (state != ST_HDR) begin
                hdr_cnt <= '0;
            end

            if (publish) begin
                sub_command <= sh_cmd;
                sub_index   <= sh_idx;
                sub_address <= sh_addr;
                sub_len     <= {5'b0, hdr_len};
                sub_more    <= sh_more;
            end

            if (data_step)              data_cnt <= data_cnt + 1'b1;
            else if (state != ST_DATA)  data_cnt <= '0;

            if (wkc_store) begin
                if (!wkc_cnt) wkc_in[7:0]  <= rx_data;
                else          wkc_in[15:8] <= rx_data;
                wkc_cnt <= ~wkc_cnt;
            end else if (state != ST_WKC) begin
                wkc_cnt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecat_datagram_parser.sv
// Self-checking bench for ecat_datagram_parser: vector table, directed
// corner cases and randomized frames against a datagram-level scoreboard.
module tb_ecat_datagram_parser;
    import ecat_pkg::*;

    logic        rxc = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_dv = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  sub_command;
    logic [7:0]  sub_index;
    logic [31:0] sub_address;
    logic [15:0] sub_len;
    logic        sub_more;
    logic        subdv;
    logic [10:0] data_idx;
    logic [15:0] wkc_in;
    logic        dgram_done;
    logic        frame_done;
    logic        err;

    ecat_datagram_parser dut (
        .rxc(rxc), .RST(rst), .rx_data(rx_data), .rx_dv(rx_dv),
        .frame_start(frame_start), .sub_command(sub_command),
        .sub_index(sub_index), .sub_address(sub_address),
        .sub_len(sub_len), .sub_more(sub_more), .subdv(subdv),
        .data_idx(data_idx), .wkc_in(wkc_in), .dgram_done(dgram_done),
        .frame_done(frame_done), .err(err)
    );

    always #5 rxc = ~rxc;

    typedef struct {
        logic fs; logic dv; logic [7:0] d;
        logic e_sdv; logic [10:0] e_idx; logic e_dg; logic e_fd; logic e_err;
    } vec_t;

    typedef struct { logic [10:0] idx; logic [7:0] b; } dbyte_t;
    typedef struct {
        logic [7:0] cmd; logic [7:0] idx; logic [31:0] addr;
        logic [15:0] len; logic more; logic [15:0] wkc; logic fd;
    } dgram_t;

    vec_t   tv[$];
    dbyte_t exp_data[$];
    dgram_t exp_dg[$];

    int checks = 0;
    int errors = 0;
    int n_sdv = 0, n_dg = 0, n_fd = 0, n_err = 0;
    bit sb_on = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic fs, input logic dv, input logic [7:0] d);
        dbyte_t eb;
        dgram_t eg;
        frame_start = fs; rx_dv = dv; rx_data = d;
        @(negedge rxc);
        if (subdv) n_sdv++;
        if (dgram_done) n_dg++;
        if (frame_done) n_fd++;
        if (err) n_err++;
        if (sb_on && subdv) begin
            if (exp_data.size() == 0) begin
                chk("unexpected_subdv", 1, 0);
            end else begin
                eb = exp_data.pop_front();
                chk("data_byte", {data_idx, rx_data}, {eb.idx, eb.b});
            end
        end
        if (sb_on && dgram_done) begin
            if (exp_dg.size() == 0) begin
                chk("unexpected_dgram_done", 1, 0);
            end else begin
                eg = exp_dg.pop_front();
                chk("dgram_fields",
                    {sub_command, sub_index, sub_address, sub_len,
                     sub_more, wkc_in, frame_done},
                    {eg.cmd, eg.idx, eg.addr, eg.len, eg.more, eg.wkc, eg.fd});
            end
        end
        @(posedge rxc); #1;
    endtask

    task automatic send_hdr(input logic fs, input logic [7:0] cmd,
                            input logic [7:0] idx, input logic [31:0] addr,
                            input logic [10:0] len, input logic more,
                            input int n);
        logic [7:0] h[10];
        h = '{cmd, idx, addr[7:0], addr[15:8], addr[23:16], addr[31:24],
              len[7:0], {more, 4'b0, len[10:8]}, 8'h5A, 8'hA5};
        for (int i = 0; i < n; i++) step(fs && (i == 0), 1'b1, h[i]);
    endtask

    task automatic send_body(input logic [10:0] len, input logic [15:0] wkc,
                             input bit push);
        logic [7:0] d;
        dbyte_t eb;
        for (int i = 0; i < int'(len); i++) begin
            d = 8'($urandom);
            eb.idx = 11'(i);
            eb.b = d;
            if (push) exp_data.push_back(eb);
            step(1'b0, 1'b1, d);
        end
        step(1'b0, 1'b1, wkc[7:0]);
        step(1'b0, 1'b1, wkc[15:8]);
    endtask

    task automatic push_dg(input logic [7:0] cmd, input logic [7:0] idx,
                           input logic [31:0] addr, input logic [10:0] len,
                           input logic more, input logic [15:0] wkc);
        dgram_t g;
        g.cmd = cmd; g.idx = idx; g.addr = addr; g.len = {5'b0, len};
        g.more = more; g.wkc = wkc; g.fd = !more;
        exp_dg.push_back(g);
    endtask

    task automatic send_dg(input logic fs, input logic [7:0] cmd,
                           input logic [7:0] idx, input logic [31:0] addr,
                           input logic [10:0] len, input logic more,
                           input logic [15:0] wkc);
        push_dg(cmd, idx, addr, len, more, wkc);
        send_hdr(fs, cmd, idx, addr, len, more, 10);
        send_body(len, wkc, 1);
    endtask

    task automatic add(input logic fs, input logic dv, input logic [7:0] d,
                       input logic es, input logic [10:0] ei, input logic edg,
                       input logic efd, input logic eer);
        vec_t v;
        v.fs = fs; v.dv = dv; v.d = d; v.e_sdv = es; v.e_idx = ei;
        v.e_dg = edg; v.e_fd = efd; v.e_err = eer;
        tv.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int b_sdv, b_dg, b_fd, b_err;
        logic [7:0] hb[10];
        logic [7:0] cmds[3];
        cmds = '{CMD_LRD, CMD_LWR, CMD_LRW};
        hb = '{8'h0A, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
               8'h04, 8'h00, 8'h00, 8'h00};

        // Test 1 vectors: header, 4 data bytes, WKC, then idle
        for (int i = 0; i < 10; i++) add(i == 0, 1, hb[i], 0, 0, 0, 0, 0);
        add(0, 1, 8'h11, 1, 0, 0, 0, 0);
        add(0, 1, 8'h22, 1, 1, 0, 0, 0);
        add(0, 1, 8'h33, 1, 2, 0, 0, 0);
        add(0, 1, 8'h44, 1, 3, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0);

        rst = 1'b1;
        repeat (3) @(posedge rxc);
        #1;
        rst = 1'b0;
        chk("reset_state",
            {sub_command, sub_index, sub_address, sub_len, sub_more, subdv,
             data_idx, wkc_in, dgram_done, frame_done, err}, '0);

        foreach (tv[i]) begin
            frame_start = tv[i].fs; rx_dv = tv[i].dv; rx_data = tv[i].d;
            @(negedge rxc);
            chk($sformatf("vec%0d", i),
                {subdv, subdv ? data_idx : 11'd0, dgram_done, frame_done, err},
                {tv[i].e_sdv, tv[i].e_idx, tv[i].e_dg, tv[i].e_fd, tv[i].e_err});
            @(posedge rxc); #1;
        end
        chk("t1_fields", {sub_command, sub_address, sub_len, sub_more, wkc_in},
            {8'h0A, 32'h0001_0000, 16'd4, 1'b0, 16'h0000});

        // Test 2: chained LWR (M=1) then LRW (M=0)
        sb_on = 1;
        b_dg = n_dg; b_fd = n_fd;
        send_dg(1, CMD_LWR, 8'h01, 32'h0000_1000, 11'd2, 1, 16'h0102);
        push_dg(CMD_LRW, 8'h02, 32'h0000_2000, 11'd1, 0, 16'h0304);
        send_hdr(0, CMD_LRW, 8'h02, 32'h0000_2000, 11'd1, 0, 9);
        chk("t2_before_byte9", {sub_command, sub_address},
            {CMD_LWR, 32'h0000_1000});
        step(0, 1, 8'hA5);
        chk("t2_after_byte9", {sub_command, sub_address},
            {CMD_LRW, 32'h0000_2000});
        send_body(11'd1, 16'h0304, 1);
        repeat (2) step(0, 0, 0);
        chk("t2_counts", {32'(n_dg - b_dg), 32'(n_fd - b_fd)}, {32'd2, 32'd1});

        // Test 3: zero length
        b_sdv = n_sdv; b_dg = n_dg;
        send_dg(1, CMD_LRD, 8'h03, 32'h0000_0030, 11'd0, 0, 16'h0005);
        repeat (2) step(0, 0, 0);
        chk("t3_counts", {32'(n_sdv - b_sdv), 32'(n_dg - b_dg)}, {32'd0, 32'd1});
        chk("t3_wkc", wkc_in, 16'h0005);

        // Test 4: truncation after data byte 2
        sb_on = 0;
        b_sdv = n_sdv; b_dg = n_dg; b_err = n_err;
        send_hdr(1, CMD_LRD, 8'h04, 32'h0000_0040, 11'd8, 0, 10);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(i));
        repeat (3) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'hEE);
        chk("t4_counts", {32'(n_sdv - b_sdv), 32'(n_dg - b_dg), 32'(n_err - b_err)},
            {32'd3, 32'd0, 32'd1});

        // Test 5: oversize, then restart at header byte 4
        sb_on = 1;
        b_sdv = n_sdv; b_err = n_err;
        send_hdr(1, CMD_LRD, 8'h05, 32'h1234_5678, 11'h7FF, 0, 10);
        step(0, 0, 0);
        chk("t5_oversize_err", 32'(n_err - b_err), 32'd1);
        chk("t5_published_len", {sub_len, sub_address}, {16'h07FF, 32'h1234_5678});
        for (int i = 0; i < 4; i++) step(0, 1, 8'h33);
        chk("t5_ignored", 32'(n_sdv - b_sdv), 32'd0);
        b_err = n_err; b_dg = n_dg;
        send_hdr(1, CMD_LWR, 8'h06, 32'hDEAD_BEEF, 11'd3, 0, 4);
        send_dg(1, CMD_LRW, 8'h07, 32'h8000_0001, 11'd3, 0, 16'hBEEF);
        repeat (2) step(0, 0, 0);
        chk("t5_restart", {32'(n_err - b_err), 32'(n_dg - b_dg)}, {32'd1, 32'd1});

        // Test 6: reset mid-DATA
        sb_on = 0;
        send_hdr(1, CMD_LRD, 8'h08, 32'h0000_0080, 11'd6, 0, 10);
        step(0, 1, 8'h01);
        step(0, 1, 8'h02);
        rst = 1'b1;
        step(0, 1, 8'hAA);
        rst = 1'b0;
        chk("t6_after_reset",
            {sub_command, sub_index, sub_address, sub_len, sub_more, subdv,
             data_idx, wkc_in, dgram_done, frame_done, err}, '0);
        b_sdv = n_sdv; b_dg = n_dg; b_err = n_err;
        for (int i = 0; i < 6; i++) step(0, 1, 8'(i + 16));
        chk("t6_ignored", {32'(n_sdv - b_sdv), 32'(n_dg - b_dg), 32'(n_err - b_err)},
            '0);

        // Randomized frames
        sb_on = 1;
        b_err = n_err; b_fd = n_fd;
        for (int f = 0; f < 40; f++) begin
            int ndg;
            ndg = int'($urandom_range(1, 3));
            for (int k = 0; k < ndg; k++) begin
                logic [10:0] len;
                len = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(9, 40))
                                                   : 11'($urandom_range(0, 8));
                send_dg(k == 0, cmds[$urandom_range(0, 2)], 8'($urandom),
                        $urandom, len, k < ndg - 1, 16'($urandom));
            end
            repeat ($urandom_range(1, 4)) step(0, 1'($urandom), 8'($urandom));
        end
        repeat (2) step(0, 0, 0);
        chk("rand_drained", {32'(exp_data.size()), 32'(exp_dg.size())}, '0);
        chk("rand_counts", {32'(n_err - b_err), 32'(n_fd - b_fd)}, {32'd0, 32'd40});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
